// File: rtl/dvp_tx_pkg.sv
// Shared definitions for the DVP test-pattern transmitter: FSM states,
// RGB565 colour-bar palette and pattern select codes.
package dvp_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StHblank,
    StVfront
  } dvp_state_e;

  // RGB565 colour bars, left to right
  localparam logic [15:0] ColorWhite   = 16'hFFFF;
  localparam logic [15:0] ColorYellow  = 16'hFFE0;
  localparam logic [15:0] ColorCyan    = 16'h07FF;
  localparam logic [15:0] ColorGreen   = 16'h07E0;
  localparam logic [15:0] ColorMagenta = 16'hF81F;
  localparam logic [15:0] ColorRed     = 16'hF800;
  localparam logic [15:0] ColorBlue    = 16'h001F;
  localparam logic [15:0] ColorBlack   = 16'h0000;

  localparam logic [1:0] PatBars    = 2'd0;
  localparam logic [1:0] PatSolid   = 2'd1;
  localparam logic [1:0] PatRamp    = 2'd2;
  localparam logic [1:0] PatChecker = 2'd3;

  // Bar index beyond 6 (including out-of-range lookahead) maps to black
  function automatic logic [15:0] bar_color(input logic [11:0] bar);
    logic [15:0] color;
    case (bar)
      12'd0:   color = ColorWhite;
      12'd1:   color = ColorYellow;
      12'd2:   color = ColorCyan;
      12'd3:   color = ColorGreen;
      12'd4:   color = ColorMagenta;
      12'd5:   color = ColorRed;
      12'd6:   color = ColorBlue;
      default: color = ColorBlack;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Test-pattern pixel generator: one registered RGB565 pixel per (x, y).
module dvp_pattern_gen
  import dvp_tx_pkg::*;
#(
  parameter logic [11:0] H_PIXEL = 12'd640
) (
  input  logic        clk_24m,
  input  logic        rst_n,
  input  logic [11:0] pix_x_i,
  input  logic [11:0] pix_y_i,
  input  logic [1:0]  sel_i,
  input  logic [15:0] solid_rgb_i,
  output logic [15:0] pixel_o
);

  localparam logic [11:0] BarWidth = H_PIXEL >> 3;

  logic [15:0] pixel_d, pixel_q;

  // Pattern select and per-pattern pixel value
  always_comb begin
    pixel_d = 16'h0000;
    unique case (sel_i)
      PatBars:    pixel_d = bar_color(pix_x_i / BarWidth);
      PatSolid:   pixel_d = solid_rgb_i;
      PatRamp:    pixel_d = {4'h0, pix_x_i} + {4'h0, pix_y_i};
      PatChecker: pixel_d = (pix_x_i[4] ^ pix_y_i[4]) ? 16'hFFFF : 16'h0000;
      default:    pixel_d = 16'h0000;
    endcase
  end

  // Output register keeps dvp_data free of combinational pattern logic
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) pixel_q <= 16'h0000;
    else        pixel_q <= pixel_d;
  end

  assign pixel_o = pixel_q;

endmodule

// File: rtl/dvp_tx_pattern.sv
// DVP camera-side transmitter: pclk = clk_24m/2, vsync/href framing and
// byte-serial RGB565 test patterns. All framing updates on the clk_24m edge
// where pclk falls, so data is stable at the receiver's pclk rising edge.
module dvp_tx_pattern
  import dvp_tx_pkg::*;
#(
  parameter logic [11:0] H_PIXEL = 12'd640,
  parameter logic [11:0] V_PIXEL = 12'd480,
  parameter logic [11:0] H_BLANK = 12'd160,
  parameter logic [7:0]  V_SYNC  = 8'd4,
  parameter logic [7:0]  V_BACK  = 8'd16,
  parameter logic [7:0]  V_FRONT = 8'd8
) (
  input  logic        clk_24m,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic        dvp_pclk,
  output logic        dvp_vsync,
  output logic        dvp_href,
  output logic [7:0]  dvp_data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int unsigned LineLen = 2 * int'(H_PIXEL) + int'(H_BLANK);
  localparam logic [13:0] LineLast   = 14'(LineLen - 1);
  localparam logic [13:0] ActLast    = 14'(2 * int'(H_PIXEL) - 1);
  localparam logic [13:0] HblankLast = 14'(int'(H_BLANK) - 1);
  localparam logic [11:0] VsyncLast  = 12'(V_SYNC) - 12'd1;
  localparam logic [11:0] VbackLast  = 12'(V_BACK) - 12'd1;
  localparam logic [11:0] VfrontLast = 12'(V_FRONT) - 12'd1;
  localparam logic [11:0] VpixLast   = V_PIXEL - 12'd1;

  dvp_state_e  state_q, state_d;
  logic        pclk_q;
  logic        tick;
  logic [13:0] h_cnt_q, h_cnt_d;
  logic [11:0] line_q, line_d;
  logic [1:0]  sel_q, sel_d;
  logic [15:0] solid_q, solid_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d;
  logic [11:0] la_x, la_y;
  logic [15:0] pixel;

  // Tick is the edge on which pclk falls, i.e. whenever pclk is currently high
  assign tick = pclk_q;

  // Lookahead coordinates: the pixel that the next tick will start sending
  always_comb begin
    la_x = 12'd0;
    la_y = 12'd0;
    if (state_q == StActive) begin
      la_x = 12'((h_cnt_q + 14'd1) >> 1);
      la_y = line_q;
    end else if (state_q == StHblank) begin
      la_y = line_q + 12'd1;
    end
  end

  dvp_pattern_gen #(
    .H_PIXEL (H_PIXEL)
  ) u_pattern_gen (
    .clk_24m     (clk_24m),
    .rst_n       (rst_n),
    .pix_x_i     (la_x),
    .pix_y_i     (la_y),
    .sel_i       (sel_q),
    .solid_rgb_i (solid_q),
    .pixel_o     (pixel)
  );

  // Frame FSM, counters and output byte mux, advancing only on tick
  always_comb begin
    state_d      = state_q;
    h_cnt_d      = h_cnt_q;
    line_d       = line_q;
    sel_d        = sel_q;
    solid_d      = solid_q;
    data_d       = data_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d = StVsync;
            h_cnt_d = 14'd0;
            line_d  = 12'd0;
            sel_d   = pattern_sel;
            solid_d = solid_rgb;
          end
        end
        StVsync: begin
          if (h_cnt_q == LineLast) begin
            h_cnt_d = 14'd0;
            if (line_q == VsyncLast) begin
              state_d = StVback;
              line_d  = 12'd0;
            end else begin
              line_d = line_q + 12'd1;
            end
          end else begin
            h_cnt_d = h_cnt_q + 14'd1;
          end
        end
        StVback: begin
          if (h_cnt_q == LineLast) begin
            h_cnt_d = 14'd0;
            if (line_q == VbackLast) begin
              state_d = StActive;
              line_d  = 12'd0;
            end else begin
              line_d = line_q + 12'd1;
            end
          end else begin
            h_cnt_d = h_cnt_q + 14'd1;
          end
        end
        StActive: begin
          if (h_cnt_q == ActLast) begin
            state_d = StHblank;
            h_cnt_d = 14'd0;
          end else begin
            h_cnt_d = h_cnt_q + 14'd1;
          end
        end
        StHblank: begin
          if (h_cnt_q == HblankLast) begin
            h_cnt_d = 14'd0;
            if (line_q == VpixLast) begin
              state_d = StVfront;
              line_d  = 12'd0;
            end else begin
              state_d = StActive;
              line_d  = line_q + 12'd1;
            end
          end else begin
            h_cnt_d = h_cnt_q + 14'd1;
          end
        end
        StVfront: begin
          if (h_cnt_q == LineLast) begin
            h_cnt_d = 14'd0;
            if (line_q == VfrontLast) begin
              line_d       = 12'd0;
              frame_done_d = 1'b1;
              frame_cnt_d  = frame_cnt_q + 8'd1;
              if (enable) begin
                state_d = StVsync;
                sel_d   = pattern_sel;
                solid_d = solid_rgb;
              end else begin
                state_d = StIdle;
              end
            end else begin
              line_d = line_q + 12'd1;
            end
          end else begin
            h_cnt_d = h_cnt_q + 14'd1;
          end
        end
        default: state_d = StIdle;
      endcase
      // Even byte index carries the high byte of the pixel
      if (state_d == StActive) data_d = h_cnt_d[0] ? pixel[7:0] : pixel[15:8];
      else                     data_d = 8'h00;
    end
  end

  // State and output registers; reset clears every output immediately
  always_ff @(posedge clk_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pclk_q       <= 1'b0;
      h_cnt_q      <= 14'd0;
      line_q       <= 12'd0;
      sel_q        <= 2'd0;
      solid_q      <= 16'h0000;
      data_q       <= 8'h00;
      frame_cnt_q  <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pclk_q       <= ~pclk_q;
      h_cnt_q      <= h_cnt_d;
      line_q       <= line_d;
      sel_q        <= sel_d;
      solid_q      <= solid_d;
      data_q       <= data_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dvp_pclk   = pclk_q;
  assign dvp_vsync  = (state_q == StVsync);
  assign dvp_href   = (state_q == StActive);
  assign dvp_data   = data_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_dvp_tx_pattern.sv
// Directed bench for dvp_tx_pattern with a tiny 8x4 frame (L = 20 pclks,
// 7 lines per frame = 140 pclks). Samples in the pclk-high phase on the
// clk_24m falling edge, where the receiver would see stable data.
module tb_dvp_tx_pattern;

  logic        clk_24m = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;
  logic        dvp_pclk, dvp_vsync, dvp_href, busy, frame_done;
  logic [7:0]  dvp_data, frame_cnt;

  dvp_tx_pattern #(
    .H_PIXEL (12'd8),
    .V_PIXEL (12'd4),
    .H_BLANK (12'd4),
    .V_SYNC  (8'd1),
    .V_BACK  (8'd1),
    .V_FRONT (8'd1)
  ) dut (
    .clk_24m     (clk_24m),
    .rst_n       (rst_n),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .dvp_pclk    (dvp_pclk),
    .dvp_vsync   (dvp_vsync),
    .dvp_href    (dvp_href),
    .dvp_data    (dvp_data),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_cnt   (frame_cnt)
  );

  always #20 clk_24m = ~clk_24m;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  // Captured frame
  int         vs_len, gap, n_lines, n_bytes, n_samples;
  bit         fd_seen;
  logic [7:0] cap [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int p, input int i, input logic [15:0] solid);
    int y = i / 16;
    int b = i % 16;
    int x = b / 2;
    logic [15:0] px;
    case (p)
      0:       px = bars[x];
      1:       px = solid;
      2:       px = 16'(x + y);
      default: px = (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 16'hFFFF : 16'h0000;
    endcase
    return (b % 2 == 0) ? px[15:8] : px[7:0];
  endfunction

  task automatic check_bytes(input string tag, input int p, input logic [15:0] solid);
    int errs = 0;
    for (int i = 0; i < 64; i++) if (cap[i] !== exp_byte(p, i, solid)) errs++;
    check(tag, errs, 0);
  endtask

  // Capture one frame up to its frame_done pulse; drop_at > 0 deasserts
  // enable and alters pattern_sel once that many bytes have been seen.
  task automatic capture_frame(input int drop_at);
    bit started = 0;
    bit seen_href = 0;
    bit prev_href = 0;
    vs_len = 0; gap = 0; n_lines = 0; n_bytes = 0; n_samples = 0; fd_seen = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_24m);
      if (frame_done) begin
        fd_seen = 1;
        break;
      end
      if (dvp_pclk) begin
        n_samples++;
        if (dvp_vsync) begin
          started = 1;
          vs_len++;
        end else if (started && !seen_href && !dvp_href) begin
          gap++;
        end
        if (dvp_href) begin
          seen_href = 1;
          if (!prev_href) n_lines++;
          if (n_bytes < 256) cap[n_bytes] = dvp_data;
          n_bytes++;
          if (n_bytes == drop_at) begin
            enable = 1'b0;
            pattern_sel = 2'd0;
          end
        end
        prev_href = dvp_href;
      end
    end
    check("frame_done_seen", 32'(fd_seen), 1);
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk_24m);
      if (frame_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int act;
    int timeouts;
    bit ok;

    // Reset, idle
    repeat (3) @(negedge clk_24m);
    check("rst_pclk", 32'(dvp_pclk), 0);
    check("rst_vsync", 32'(dvp_vsync), 0);
    check("rst_href", 32'(dvp_href), 0);
    check("rst_data", 32'(dvp_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fdone", 32'(frame_done), 0);
    check("rst_fcnt", 32'(frame_cnt), 0);
    rst_n = 1'b1;
    @(negedge clk_24m);
    check("pclk_first", 32'(dvp_pclk), 1);
    @(negedge clk_24m);
    check("pclk_second", 32'(dvp_pclk), 0);
    act = 0;
    repeat (1000) begin
      @(negedge clk_24m);
      if (dvp_vsync || dvp_href || busy || frame_done) act++;
    end
    check("idle_quiet", act, 0);

    // Frame A: colour bars from idle
    pattern_sel = 2'd0;
    enable = 1'b1;
    capture_frame(0);
    check("a_vsync_len", vs_len, 20);
    check("a_vback_gap", gap, 20);
    check("a_lines", n_lines, 4);
    check("a_bytes", n_bytes, 64);
    check("a_byte3", 32'(cap[3]), 32'hE0);
    check("a_byte8", 32'(cap[8]), 32'hF8);
    check_bytes("a_bars", 0, 16'h0000);
    check("a_fcnt", 32'(frame_cnt), 1);

    // Frame B already latched bars; selection change must not show yet
    pattern_sel = 2'd1;
    solid_rgb = 16'hA5C3;
    capture_frame(0);
    check_bytes("b_bars_kept", 0, 16'h0000);
    check("b_period", n_samples, 140);

    // Frame C: solid
    pattern_sel = 2'd2;
    capture_frame(0);
    check_bytes("c_solid", 1, 16'hA5C3);
    check("c_period", n_samples, 140);
    check("c_fcnt", 32'(frame_cnt), 3);

    // Frame D: ramp
    pattern_sel = 2'd3;
    capture_frame(0);
    check_bytes("d_ramp", 2, 16'h0000);
    check("d_y3x7_hi", 32'(cap[62]), 32'h00);
    check("d_y3x7_lo", 32'(cap[63]), 32'h0A);
    check("d_fcnt", 32'(frame_cnt), 4);

    // Frame E: checker; enable dropped mid line 2 and pattern changed
    capture_frame(40);
    check_bytes("e_checker", 3, 16'h0000);
    check("e_bytes", n_bytes, 64);
    check("e_fcnt", 32'(frame_cnt), 5);
    repeat (2) @(negedge clk_24m);
    check("e_busy_low", 32'(busy), 0);
    act = 0;
    repeat (1000) begin
      @(negedge clk_24m);
      if (dvp_vsync || busy) act++;
    end
    check("e_no_restart", act, 0);

    // Reset in the middle of an active line
    pattern_sel = 2'd1;
    solid_rgb = 16'hA5C3;
    enable = 1'b1;
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk_24m);
      if (dvp_href) begin
        ok = 1;
        break;
      end
    end
    check("r_href_found", 32'(ok), 1);
    repeat (3) @(negedge clk_24m);
    #5 rst_n = 1'b0;
    #1;
    check("r_href", 32'(dvp_href), 0);
    check("r_vsync", 32'(dvp_vsync), 0);
    check("r_data", 32'(dvp_data), 0);
    check("r_busy", 32'(busy), 0);
    check("r_fcnt", 32'(frame_cnt), 0);
    @(negedge clk_24m);
    rst_n = 1'b1;
    capture_frame(0);
    check("r_vsync_len", vs_len, 20);
    check("r_bytes", n_bytes, 64);
    check_bytes("r_solid", 1, 16'hA5C3);
    check("r_fcnt_after", 32'(frame_cnt), 1);

    // Run on to the frame counter wrap
    timeouts = 0;
    for (int f = 0; f < 254; f++) begin
      wait_done(ok);
      if (!ok) timeouts++;
    end
    check("w_timeouts", timeouts, 0);
    check("w_fcnt_255", 32'(frame_cnt), 255);
    wait_done(ok);
    check("w_last_done", 32'(ok), 1);
    check("w_fcnt_wrap", 32'(frame_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
